nibble_serial_adder: RTL and testbench
======================================

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, setting the operand width W = 4*NIBBLES bits; legal values are 2 to 16.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port start, input, 1 bit: request to begin an addition.
REQ-005 Port op_a, input, W bits: first operand, sampled on the accept edge.
REQ-006 Port op_b, input, W bits: second operand, sampled on the accept edge.
REQ-007 Port cin, input, 1 bit: carry-in, sampled on the accept edge.
REQ-008 Port busy, output, 1 bit: high while the block is in RUN.
REQ-009 Port done, output, 1 bit: one-cycle pulse when result and cout become valid.
REQ-010 Port result, output, W bits: sum, held stable until the next accept.
REQ-011 Port cout, output, 1 bit: final carry-out, held stable with result.
REQ-012 Port add_a, output, 4 bits: nibble A driven to the external 4-bit full adder.
REQ-013 Port add_b, output, 4 bits: nibble B driven to the external 4-bit full adder.
REQ-014 Port add_cin, output, 1 bit: carry driven to the external full adder.
REQ-015 Port add_sum, input, 4 bits: combinational sum returned by the full adder.
REQ-016 Port add_cout, input, 1 bit: combinational carry returned by the full adder.

Function
REQ-017 The block SHALL use a state machine with states IDLE, RUN and DONE.
REQ-018 Accept rule: start SHALL be accepted only in IDLE or DONE; on the accept edge the block SHALL latch op_a, op_b and cin, set nibble index idx=0, load the carry register from cin, and enter RUN.
REQ-019 start in RUN SHALL be ignored, with no effect on any register or output.
REQ-020 In RUN, the adder drive SHALL be combinational from registers:
- add_a = A_reg[4*idx+3:4*idx]
- add_b = B_reg[4*idx+3:4*idx]
- add_cin = carry register
REQ-021 Outside RUN, add_a, add_b and add_cin SHALL be driven to 0.
REQ-022 On each RUN edge, the block SHALL:
- write add_sum into result nibble idx;
- load add_cout into the carry register;
- increment idx.
REQ-023 On the RUN edge with idx = NIBBLES-1, the block SHALL also load cout from add_cout and move to DONE.
REQ-024 Latency: done SHALL be high for exactly one cycle, starting NIBBLES rising edges after the accept edge; busy SHALL be high for exactly those NIBBLES cycles.
REQ-025 From DONE without start, the block SHALL return to IDLE on the next edge; done SHALL deassert.
REQ-026 start in the DONE cycle SHALL be accepted (back-to-back operation); done then lasts one cycle and busy rises on the next cycle.
REQ-027 Arithmetic: {cout, result} SHALL equal op_a + op_b + cin, modulo 2^(W+1), with no truncation.
REQ-028 Result nibbles not yet written in RUN SHALL retain their previous values; result and cout are valid only from done onward.
REQ-029 Operand changes on op_a, op_b and cin after the accept edge SHALL NOT affect the running addition.

Reset
REQ-030 When rst is high at a rising edge, the block SHALL enter IDLE and clear all of the following to 0:
- outputs busy, done, result and cout;
- idx, the carry register and the operand registers.
REQ-031 rst SHALL take priority over start and over any operation in progress; a reset mid-RUN SHALL abort the operation with no done pulse.

Verification
REQ-032 NIBBLES=4; op_a=0x00FF, op_b=0x0001, cin=0 -> result=0x0100, cout=0, done exactly 4 edges after accept, busy high 4 cycles.
REQ-033 op_a=0xFFFF, op_b=0x0001, cin=0 -> result=0x0000, cout=1; this checks carry propagation through all nibbles.
REQ-034 op_a=0x1234, op_b=0x4321, cin=1 -> result=0x5556, cout=0; op_a changed to 0xAAAA on the edge after accept -> result unchanged.
REQ-035 start pulsed at cycle 2 of RUN with different operands -> ignored; the first result completes unchanged.
REQ-036 rst asserted at cycle 2 of RUN -> next cycle busy=0, done=0, result=0x0000, cout=0, state IDLE, with no done pulse afterwards.
REQ-037 start held high in the DONE cycle with 0x8000+0x8000, cin=0 -> second operation accepted; result=0x0000, cout=1, second done 4 edges later.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - multi-cycle adder that walks W-bit operands one nibble per cycle
// through an external 4-bit full adder, least significant nibble first.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_sum,
    input  logic                   add_cout
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic            carry;
    logic [IW-1:0]   idx;
    logic            accept;
    logic            last;

    assign last = (idx == IW'(NIBBLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A new request is taken from IDLE and also from DONE, so operations can run back to back.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        add_a   = 4'd0;
        add_b   = 4'd0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_reg[{idx, 2'b00} +: 4];
            add_b   = b_reg[{idx, 2'b00} +: 4];
            add_cin = carry;
        end
    end

    // result is not cleared on accept: unwritten nibbles keep their old value until overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            result <= '0;
            cout   <= 1'b0;
        end else if (accept) begin
            a_reg <= op_a;
            b_reg <= op_b;
            carry <= cin;
            idx   <= '0;
        end else if (state == RUN) begin
            result[{idx, 2'b00} +: 4] <= add_sum;
            carry                     <= add_cout;
            idx                       <= idx + IW'(1);
            if (last) begin
                cout <= add_cout;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed and randomized checks of nibble_serial_adder
// against plain wide arithmetic, with a behavioural 4-bit adder on the side port.
module tb_nibble_serial_adder;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          cin;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          cout;
    logic [3:0]    add_a;
    logic [3:0]    add_b;
    logic          add_cin;
    logic [3:0]    add_sum;
    logic          add_cout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // disturb: 0 none, 1 scramble operands after accept, 2 pulse start with other operands in RUN cycle 2
    // chain: leave the block in its DONE cycle so the caller can issue a back-to-back start
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input int disturb, input bit chain, input string tag);
        logic [W:0] expv;
        int lat;
        int busy_cnt;
        expv  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        op_a  = a;
        op_b  = b;
        cin   = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
        chk({tag, "_done_low"}, {31'd0, done}, 32'd0);
        chk({tag, "_add_a0"}, {28'd0, add_a}, {28'd0, a[3:0]});
        if (disturb == 1) begin
            op_a = 16'hAAAA;
            op_b = W'($urandom);
            cin  = ~c;
        end
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            tick();
            lat++;
            if (disturb == 2 && lat == 1) begin
                start = 1'b1;
                op_a  = ~a;
                op_b  = W'($urandom);
                cin   = ~c;
            end else begin
                start = 1'b0;
            end
        end
        chk({tag, "_no_timeout"}, {31'd0, done}, 32'd1);
        chk({tag, "_latency"}, lat, NIBBLES);
        chk({tag, "_busy_cycles"}, busy_cnt, NIBBLES);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_result"}, {16'd0, result}, {16'd0, expv[W-1:0]});
        chk({tag, "_cout"}, {31'd0, cout}, {31'd0, expv[W]});
        chk({tag, "_adder_idle"}, {23'd0, add_a, add_b, add_cin}, 32'd0);
        if (!chain) begin
            tick();
            chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
            chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
            chk({tag, "_result_held"}, {16'd0, result}, {16'd0, expv[W-1:0]});
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_adder", {23'd0, add_a, add_b, add_cin}, 32'd0);
        rst = 1'b0;
        tick();

        do_op(16'h00FF, 16'h0001, 1'b0, 0, 1'b0, "ff_plus_1");
        do_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, "full_carry");
        do_op(16'h1234, 16'h4321, 1'b1, 1, 1'b0, "operand_change");
        do_op(16'h0F0F, 16'hF0F1, 1'b0, 2, 1'b0, "start_in_run");

        // Reset two cycles into RUN: outputs clear and no done follows.
        op_a  = 16'h7777;
        op_b  = 16'h1111;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_result", {16'd0, result}, 32'd0);
        chk("midrst_cout", {31'd0, cout}, 32'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (done || busy) seen++;
            end
            chk("midrst_quiet", seen, 0);
        end

        do_op(16'h00FF, 16'h0001, 1'b0, 0, 1'b1, "b2b_first");
        do_op(16'h8000, 16'h8000, 1'b0, 0, 1'b0, "b2b_second");

        for (int i = 0; i < 24; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                  1'($urandom), $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
